// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types and constants for the IF/MEM single-port RAM
//               arbiter: FSM state encoding, grant ids, access counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    // Width of the access-latency down-counter (covers LATENCY 1..15)
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    typedef enum logic {
        GNT_IF   = 1'b0,
        GNT_DATA = 1'b1
    } grant_t;

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_access_timer.sv
`default_nettype none
// ============================================================================
// Module      : access_timer
// Description : Loadable down-counter that times one RAM access. Loads the
//               remaining cycle count, decrements while enabled and flags
//               zero on the last access cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module access_timer
    import mem_arb_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] value,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] r_cnt;

    // Load has priority over decrement; the count saturates at zero
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= value;
        end else if (dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign zero = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one single-port RAM between instruction fetch and
//               load/store. Round-robin arbitration on contention, LATENCY-
//               cycle access sequencing, one-cycle ready pulses and the
//               pipeline freeze signals.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int LATENCY = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              mem_rd_req,
    input  logic              mem_wr_req,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ready,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              freeze_if,
    output logic              freeze_pipe
);

    localparam logic [CNT_W-1:0] C_LOAD_VAL = CNT_W'(LATENCY - 1);

    state_t r_state;
    state_t w_state_next;
    grant_t r_grant;
    grant_t r_last_grant;
    grant_t w_grant;
    logic   r_write;
    logic   w_data_req;
    logic   w_start;
    logic   w_capture;
    logic   w_timer_zero;

    assign w_data_req = mem_rd_req | mem_wr_req;

    // Arbitration: data port wins contention unless it won the previous grant
    always_comb begin
        w_grant = GNT_IF;
        if (w_data_req && (!if_req || (r_last_grant != GNT_DATA))) begin
            w_grant = GNT_DATA;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and RAM/ready strobes; strobes depend only on state so reset kills them at once
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_capture    = 1'b0;
        ram_en       = 1'b0;
        ram_we       = 1'b0;
        if_ready     = 1'b0;
        mem_ready    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (if_req || w_data_req) begin
                    w_start      = 1'b1;
                    w_state_next = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                ram_en = 1'b1;
                ram_we = w_timer_zero & r_write;
                if (w_timer_zero) begin
                    w_capture    = 1'b1;
                    w_state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                if_ready     = (r_grant == GNT_IF);
                mem_ready    = (r_grant == GNT_DATA);
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Request latches: sampled only at grant, later input changes are ignored
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_grant      <= GNT_IF;
            r_last_grant <= GNT_IF;
            r_write      <= 1'b0;
            ram_addr     <= '0;
            ram_wdata    <= '0;
        end else if (w_start) begin
            r_grant      <= w_grant;
            r_last_grant <= w_grant;
            if (w_grant == GNT_DATA) begin
                ram_addr  <= mem_addr;
                ram_wdata <= mem_wdata;
                r_write   <= mem_wr_req;
            end else begin
                ram_addr  <= if_addr;
                r_write   <= 1'b0;
            end
        end
    end

    // Read data capture on the last access cycle; stores leave the data registers alone
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_rdata  <= '0;
            mem_rdata <= '0;
        end else if (w_capture && !r_write) begin
            if (r_grant == GNT_IF) begin
                if_rdata <= ram_rdata;
            end else begin
                mem_rdata <= ram_rdata;
            end
        end
    end

    access_timer u_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (w_start),
        .value (C_LOAD_VAL),
        .dec   (r_state == ST_ACCESS),
        .zero  (w_timer_zero)
    );

    assign freeze_pipe = w_data_req & ~mem_ready;
    assign freeze_if   = (if_req & ~if_ready) | freeze_pipe;

endmodule
`default_nettype wire
